pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline register (E/M style).
- Carries one packed payload per instruction between two pipeline stages.
- Adds valid/ready handshake, optional 2-entry skid buffer, per-instruction nullify (kill), synchronous flush, and a saturating stall counter for performance probing.
- Instantiated once per stage boundary (D/E, E/M, M/W), with payload width set by the instantiating stage.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_stage_reg_sat_counter.sv | 37 +++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: state encoding,
// default payload widths per stage boundary, and the E/M payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  // Default payload widths per stage boundary
  localparam int unsigned DE_W = 96;
  localparam int unsigned EM_W = 136;
  localparam int unsigned MW_W = 72;

  // E/M payload field offsets (LSB positions)
  localparam int unsigned EM_ALU_LSB   = 0;
  localparam int unsigned EM_SD_LSB    = 32;
  localparam int unsigned EM_PC4_LSB   = 64;
  localparam int unsigned EM_INSTR_LSB = 96;
  localparam int unsigned EM_WREG_LSB  = 128;
  localparam int unsigned EM_CTRL_LSB  = 133;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [4:0]  wreg;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] sd;
    logic [31:0] alu;
  } em_payload_t;

  // Packs E/M fields into a flat payload at the documented offsets
  function automatic logic [EM_W-1:0] em_pack(input em_payload_t p);
    logic [EM_W-1:0] v;
    v = '0;
    v[EM_ALU_LSB   +: 32] = p.alu;
    v[EM_SD_LSB    +: 32] = p.sd;
    v[EM_PC4_LSB   +: 32] = p.pc4;
    v[EM_INSTR_LSB +: 32] = p.instr;
    v[EM_WREG_LSB  +: 5]  = p.wreg;
    v[EM_CTRL_LSB  +: 3]  = p.ctrl;
    return v;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for performance probes.
// Ports: clk, rst_n (async active-low), inc_i (count this cycle),
//        clr_i (synchronous clear, wins over inc_i), cnt_o (count value).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer, per-entry kill, synchronous flush and a saturating
// stall counter.
// Ports: clk, reset (async active-low);
//        upstream   in_valid, in_ready, in_data, in_kill;
//        downstream out_valid, out_ready, out_data (zero when not valid);
//        control    flush, cnt_clr; probe stall_cnt.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EM_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push;
  logic              pop;
  logic              ready_int;

  // With a skid buffer, ready depends only on state; without, downstream
  // ready passes straight through when the single slot is occupied.
  generate
    if (SKID != 0) begin : g_skid
      assign ready_int = (state_q != TWO);
    end else begin : g_noskid
      assign ready_int = (state_q == EMPTY) | out_ready;
    end
  endgenerate

  assign push = in_valid & ready_int & ~in_kill;
  assign pop  = out_valid & out_ready;

  // Next-state and data-register update; flush overrides everything
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push && (SKID != 0)) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Main register is zeroed whenever empty, so it drives out_data directly
  assign out_valid = (state_q == ONE) || (state_q == TWO);
  assign out_data  = main_q;
  assign in_ready  = ready_int;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (in_valid & ~ready_int),
    .clr_i (cnt_clr),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          k;
    logic          r;
    logic          f;
    logic          c;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
  } vec_t;

  logic clk;
  logic reset;

  // SKID=1 instance signals
  logic          v1, k1, r1, f1, c1, rdy1, ov1;
  logic [DW-1:0] d1, od1;
  logic [CW-1:0] cnt1;

  // SKID=0 instance signals
  logic          v0, k0, r0, f0, c0, rdy0, ov0;
  logic [DW-1:0] d0, od0;
  logic [CW-1:0] cnt0;

  int n_chk;
  int n_fail;
  int takes1;
  logic [DW-1:0] sb_q[$];

  vec_t tv1[18];
  vec_t tv0[7];

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_kill(k1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1),
    .flush(f1), .cnt_clr(c1), .stall_cnt(cnt1)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_kill(k0),
    .out_valid(ov0), .out_ready(r0), .out_data(od0),
    .flush(f0), .cnt_clr(c0), .stall_cnt(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d,
                              input logic k, input logic r, input logic f,
                              input logic c, input logic e_ov,
                              input logic [DW-1:0] e_od, input logic e_ir);
    vec_t t;
    t.v = v; t.d = d; t.k = k; t.r = r; t.f = f; t.c = c;
    t.e_ov = e_ov; t.e_od = e_od; t.e_ir = e_ir;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SKID=1: drive at negedge, count handshake, check outputs after the edge
  task automatic step1(input vec_t t, input int idx);
    @(negedge clk);
    v1 = t.v; d1 = t.d; k1 = t.k; r1 = t.r; f1 = t.f; c1 = t.c;
    #1;
    if (v1 && rdy1) takes1++;
    @(posedge clk);
    #1;
    check($sformatf("s1[%0d] out_valid", idx), 32'(ov1), 32'(t.e_ov));
    check($sformatf("s1[%0d] out_data", idx), 32'(od1), 32'(t.e_od));
    check($sformatf("s1[%0d] in_ready", idx), 32'(rdy1), 32'(t.e_ir));
  endtask

  // SKID=0: in_ready checked before the edge (combinational), plus scoreboard
  task automatic step0(input vec_t t, input int idx);
    logic [DW-1:0] exp_d;
    @(negedge clk);
    v0 = t.v; d0 = t.d; k0 = t.k; r0 = t.r; f0 = t.f; c0 = t.c;
    #1;
    check($sformatf("s0[%0d] in_ready", idx), 32'(rdy0), 32'(t.e_ir));
    if (ov0 && r0) begin
      if (sb_q.size() == 0) begin
        check($sformatf("s0[%0d] unexpected pop", idx), 32'(1), 32'(0));
      end else begin
        exp_d = sb_q.pop_front();
        check($sformatf("s0[%0d] pop data", idx), 32'(od0), 32'(exp_d));
      end
    end
    if (v0 && rdy0 && !k0) sb_q.push_back(d0);
    @(posedge clk);
    #1;
    check($sformatf("s0[%0d] out_valid", idx), 32'(ov0), 32'(t.e_ov));
    check($sformatf("s0[%0d] out_data", idx), 32'(od0), 32'(t.e_od));
  endtask

  initial begin
    n_chk = 0; n_fail = 0; takes1 = 0;
    reset = 1'b0;
    v1 = 0; d1 = '0; k1 = 0; r1 = 0; f1 = 0; c1 = 0;
    v0 = 0; d0 = '0; k0 = 0; r0 = 0; f0 = 0; c0 = 0;

    //              v  d       k  r  f  c  ov od      ir
    tv1[0]  = mk(1, 16'h11, 0, 0, 0, 0, 1, 16'h11, 1);  // push -> ONE
    tv1[1]  = mk(1, 16'h22, 0, 0, 0, 0, 1, 16'h11, 0);  // push, no pop -> TWO
    tv1[2]  = mk(1, 16'h33, 0, 0, 0, 0, 1, 16'h11, 0);  // stalled
    tv1[3]  = mk(0, 16'h00, 0, 1, 0, 0, 1, 16'h22, 1);  // pop -> ONE, skid moves up
    tv1[4]  = mk(0, 16'h00, 0, 1, 0, 0, 0, 16'h00, 1);  // pop -> EMPTY
    tv1[5]  = mk(1, 16'h01, 0, 1, 0, 0, 1, 16'h01, 1);  // kill stream
    tv1[6]  = mk(1, 16'h02, 1, 1, 0, 0, 0, 16'h00, 1);  // killed -> bubble
    tv1[7]  = mk(1, 16'h03, 0, 1, 0, 0, 1, 16'h03, 1);
    tv1[8]  = mk(0, 16'h00, 0, 1, 0, 0, 0, 16'h00, 1);
    tv1[9]  = mk(1, 16'h55, 0, 0, 0, 0, 1, 16'h55, 1);  // ONE with 0x55
    tv1[10] = mk(1, 16'h66, 0, 1, 1, 0, 0, 16'h00, 1);  // flush wins
    tv1[11] = mk(0, 16'h00, 0, 0, 0, 0, 0, 16'h00, 1);
    tv1[12] = mk(0, 16'h77, 1, 1, 0, 0, 0, 16'h00, 1);  // kill without valid
    tv1[13] = mk(1, 16'hA1, 0, 0, 0, 0, 1, 16'hA1, 1);
    tv1[14] = mk(1, 16'hA2, 0, 1, 0, 0, 1, 16'hA2, 1);  // push&pop in ONE
    tv1[15] = mk(1, 16'hA3, 0, 0, 0, 0, 1, 16'hA2, 0);  // -> TWO
    tv1[16] = mk(1, 16'hA4, 0, 1, 0, 0, 1, 16'hA3, 1);  // pop only (not ready)
    tv1[17] = mk(0, 16'h00, 0, 0, 1, 0, 0, 16'h00, 1);  // flush from ONE

    tv0[0] = mk(1, 16'h1, 0, 1, 0, 0, 1, 16'h1, 1);
    tv0[1] = mk(1, 16'h2, 0, 0, 0, 0, 1, 16'h1, 0);
    tv0[2] = mk(1, 16'h2, 0, 1, 0, 0, 1, 16'h2, 1);
    tv0[3] = mk(1, 16'h3, 0, 0, 0, 0, 1, 16'h2, 0);
    tv0[4] = mk(1, 16'h3, 0, 1, 0, 0, 1, 16'h3, 1);
    tv0[5] = mk(0, 16'h0, 0, 1, 0, 0, 0, 16'h0, 1);
    tv0[6] = mk(1, 16'h4, 1, 1, 0, 0, 0, 16'h0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(ov1), 32'(0));
    check("rst out_data", 32'(od1), 32'(0));
    check("rst in_ready", 32'(rdy1), 32'(1));
    check("rst stall_cnt", 32'(cnt1), 32'(0));
    check("rst0 out_valid", 32'(ov0), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) step1(tv1[i], i);
    check("handshake count", 32'(takes1), 32'(10));
    check("stall_cnt after table", 32'(cnt1), 32'(2));

    // Reset mid-stream while holding 0xA/0xB in TWO
    step1(mk(1, 16'hA, 0, 0, 0, 0, 1, 16'hA, 1), 100);
    step1(mk(1, 16'hB, 0, 0, 0, 0, 1, 16'hA, 0), 101);
    step1(mk(1, 16'hC, 0, 0, 0, 0, 1, 16'hA, 0), 102);
    check("pre-reset stall_cnt", 32'(cnt1), 32'(3));
    #2;
    reset = 1'b0;
    #1;
    check("async rst out_valid", 32'(ov1), 32'(0));
    check("async rst out_data", 32'(od1), 32'(0));
    check("async rst in_ready", 32'(rdy1), 32'(1));
    check("async rst stall_cnt", 32'(cnt1), 32'(0));
    v1 = 0;
    @(negedge clk);
    reset = 1'b1;

    // Stall counter saturation
    step1(mk(1, 16'h1, 0, 0, 0, 0, 1, 16'h1, 1), 200);
    step1(mk(1, 16'h2, 0, 0, 0, 0, 1, 16'h1, 0), 201);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) check("stall_cnt mid", 32'(cnt1), 32'(10));
    end
    check("stall_cnt saturated", 32'(cnt1), 32'(15));
    @(posedge clk);
    #1;
    check("stall_cnt holds", 32'(cnt1), 32'(15));
    step1(mk(1, 16'h3, 0, 0, 0, 1, 1, 16'h1, 0), 202);
    check("cnt_clr wins", 32'(cnt1), 32'(0));
    step1(mk(1, 16'h3, 0, 0, 0, 0, 1, 16'h1, 0), 203);
    check("stall_cnt restart", 32'(cnt1), 32'(1));
    step1(mk(0, 16'h0, 0, 1, 0, 0, 1, 16'h2, 1), 204);
    step1(mk(0, 16'h0, 0, 1, 0, 0, 0, 16'h0, 1), 205);

    // SKID=0 throughput with toggling out_ready
    for (int i = 0; i < 7; i++) step0(tv0[i], i);
    check("s0 scoreboard drained", 32'(sb_q.size()), 32'(0));
    check("s0 stall_cnt", 32'(cnt0), 32'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
